// File: rtl/mul_rr_sched_pkg.sv
// mul_rr_sched_pkg
// Shared definitions for the multiplier scheduler slice:
//   - default operand width and requester count
//   - requester-ID width helper (clog2, at least 1 bit)
//   - result-register state enum
package mul_rr_sched_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_REQ    = 4;

  // Result register is either empty or holding one product for its owner.
  typedef enum logic {
    RES_EMPTY = 1'b0,
    RES_FULL  = 1'b1
  } res_state_e;

  // ID width for n requesters; a single requester still gets a 1-bit ID.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mul_rr_sched_rr_arb.sv
// rr_arb
// Purely combinational round-robin arbiter.
// Ports:
//   req      in  N     request vector
//   ptr      in  ID_W  highest-priority index for this cycle
//   en       in  1     allows the grant to be driven
//   grant    out N     one-hot grant (zero when en=0 or no request)
//   grant_id out ID_W  index of the winner (valid when any=1)
//   any      out 1     at least one request asserted, independent of en
module rr_arb #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id,
  output logic            any
);

  // Walk the requests starting at ptr and wrapping; the first set bit wins.
  always_comb begin
    int idx;
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        any      = 1'b1;
        grant_id = ID_W'(idx);
      end
    end
    if (en && any) begin
      grant[grant_id] = 1'b1;
    end
  end

endmodule

// File: rtl/mul_rr_sched.sv
// mul_rr_sched
// One signed multiplier shared among NUM_REQ requesters, round-robin arbitrated,
// with a one-entry result register routed back to the granted requester.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   req_valid    in  NUM_REQ            operand valid per requester
//   req_ready    out NUM_REQ            one-hot accept (zero in reset/backpressure)
//   req_a/req_b  in  NUM_REQ*DATA_WIDTH flattened operands, slice i at [i*DW +: DW]
//   resp_valid   out NUM_REQ            one-hot result valid
//   resp_ready   in  NUM_REQ            result accept (only the owner's bit matters)
//   resp_data    out DATA_WIDTH         truncated product, broadcast
//   resp_id      out ID_W               owner of resp_data
//   op_count     out 32                 accepted operations, wrapping
module mul_rr_sched
  import mul_rr_sched_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ID_W       = id_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]            resp_valid,
  input  logic [NUM_REQ-1:0]            resp_ready,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic [ID_W-1:0]               resp_id,
  output logic [31:0]                   op_count
);

  res_state_e state_q, state_d;

  logic                         full, drain, can_accept, accept;
  logic [NUM_REQ-1:0]           grant;
  logic [ID_W-1:0]              grant_id;
  logic                         any_req;
  logic [ID_W-1:0]              ptr_q, ptr_next;
  logic [DATA_WIDTH-1:0]        data_q;
  logic [ID_W-1:0]              id_q;
  logic [31:0]                  count_q;
  logic signed [DATA_WIDTH-1:0] op_a, op_b;
  logic [DATA_WIDTH-1:0]        product;

  assign full       = (state_q == RES_FULL);
  assign drain      = full & resp_ready[id_q];
  // A draining result frees the slot in the same edge, so a new product can replace it.
  assign can_accept = ~full | drain;

  rr_arb #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .req      (req_valid),
    .ptr      (ptr_q),
    .en       (can_accept & ~rst),
    .grant    (grant),
    .grant_id (grant_id),
    .any      (any_req)
  );

  assign req_ready = grant;
  assign accept    = any_req & |(req_valid & grant);

  // Truncated product; low bits are the same for signed and unsigned operands.
  assign op_a    = req_a[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
  assign op_b    = req_b[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
  assign product = DATA_WIDTH'(op_a * op_b);

  assign ptr_next = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;

  // Result-register next state: accept always fills, a bare drain empties.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RES_EMPTY: if (accept) state_d = RES_FULL;
      RES_FULL: begin
        if (accept)     state_d = RES_FULL;
        else if (drain) state_d = RES_EMPTY;
      end
      default: state_d = RES_EMPTY;
    endcase
  end

  // State, payload, pointer and counter; data/id hold across a bare drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RES_EMPTY;
      data_q  <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q  <= product;
        id_q    <= grant_id;
        ptr_q   <= ptr_next;
        count_q <= count_q + 32'd1;
      end
    end
  end

  // Response valid is routed only to the owner of the held result.
  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid[i] = full && (int'(id_q) == i);
    end
  end

  assign resp_data = data_q;
  assign resp_id   = id_q;
  assign op_count  = count_q;

endmodule

// File: tb/tb_mul_rr_sched.sv
// tb_mul_rr_sched
// Self-checking bench: directed scenarios plus randomized traffic, all compared
// every cycle against a behavioural model of the scheduler.
module tb_mul_rr_sched;

  localparam int DW = 32;
  localparam int NR = 4;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req_valid, req_ready, resp_valid, resp_ready;
  logic [NR*DW-1:0] req_a, req_b;
  logic [DW-1:0]    resp_data;
  logic [1:0]       resp_id;
  logic [31:0]      op_count;

  mul_rr_sched #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .op_count   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: what the result slot should hold and where priority points.
  logic [DW-1:0] opa [NR];
  logic [DW-1:0] opb [NR];
  int            m_ptr;
  bit            m_full;
  logic [DW-1:0] m_data;
  int            m_id;
  logic [31:0]   m_cnt;
  int            last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic setOp(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    opa[i] = a;
    opb[i] = b;
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
  endtask

  function automatic logic [DW-1:0] mProduct(input int i);
    logic signed [63:0] pa, pb, p;
    pa = {{32{opa[i][DW-1]}}, opa[i]};
    pb = {{32{opb[i][DW-1]}}, opb[i]};
    p  = pa * pb;
    return p[31:0];
  endfunction

  function automatic int mWinner(input logic [NR-1:0] v);
    for (int k = 0; k < NR; k++) begin
      if (v[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    end
    return -1;
  endfunction

  function automatic logic [NR-1:0] mReady(input logic [NR-1:0] v, input logic [NR-1:0] rr, input logic r);
    int w;
    if (r) return '0;
    if (m_full && !rr[m_id]) return '0;
    w = mWinner(v);
    if (w < 0) return '0;
    return NR'(1 << w);
  endfunction

  task automatic modelReset();
    m_ptr  = 0;
    m_full = 0;
    m_data = '0;
    m_id   = 0;
    m_cnt  = '0;
  endtask

  // Compare every DUT output against the model for the inputs now applied.
  task automatic checkOutput();
    chk("req_ready",  32'(req_ready), 32'(mReady(req_valid, resp_ready, rst)));
    chk("resp_valid", 32'(resp_valid), m_full ? 32'(1 << m_id) : 32'd0);
    chk("resp_data",  resp_data, m_data);
    chk("resp_id",    32'(resp_id), 32'(m_id));
    chk("op_count",   op_count, m_cnt);
  endtask

  task automatic applyStimulus(input logic [NR-1:0] v, input logic [NR-1:0] rr, input logic r);
    req_valid  = v;
    resp_ready = rr;
    rst        = r;
    #1;
    checkOutput();
  endtask

  // Advance one clock edge and evolve the model by the same inputs.
  task automatic tick();
    int  w;
    bit  drn;
    @(posedge clk);
    w = (mReady(req_valid, resp_ready, rst) != '0) ? mWinner(req_valid) : -1;
    last_acc = -1;
    if (rst) begin
      modelReset();
    end else begin
      drn = m_full && resp_ready[m_id];
      if (w >= 0) begin
        m_data   = mProduct(w);
        m_id     = w;
        m_full   = 1;
        m_ptr    = (w + 1) % NR;
        m_cnt    = m_cnt + 1;
        last_acc = w;
      end else if (drn) begin
        m_full = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic doReset();
    applyStimulus('0, '0, 1'b1);
    tick();
  endtask

  initial begin
    logic [NR-1:0] v;
    logic [NR-1:0] rr;
    logic          r;

    rst = 1'b1; req_valid = '0; resp_ready = '0; req_a = '0; req_b = '0;
    for (int i = 0; i < NR; i++) setOp(i, '0, '0);
    repeat (2) @(posedge clk);
    modelReset();
    @(negedge clk);
    checkOutput();
    chk("reset op_count", op_count, 32'd0);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);

    // Single multiply with a negative operand.
    setOp(0, 32'd7, -32'sd3);
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    chk("t1 req_ready", 32'(req_ready), 32'h1);
    tick();
    chk("t1 resp_valid", 32'(resp_valid), 32'h1);
    chk("t1 resp_data", resp_data, 32'hFFFFFFEB);
    chk("t1 resp_id", 32'(resp_id), 32'd0);
    chk("t1 op_count", op_count, 32'd1);

    // Full-rate round robin across all four requesters.
    doReset();
    for (int i = 0; i < NR; i++) setOp(i, 32'(i + 1), 32'd10);
    for (int k = 0; k < NR; k++) begin
      applyStimulus(4'b1111, 4'b1111, 1'b0);
      tick();
      chk("t2 resp_id", 32'(resp_id), 32'(k));
      chk("t2 resp_data", resp_data, 32'(10 * (k + 1)));
    end
    applyStimulus(4'b1111, 4'b1111, 1'b0);
    chk("t2 ptr wrap", 32'(req_ready), 32'h1);
    tick();

    // Backpressure on requester 2's result while 1 and 3 wait.
    doReset();
    setOp(1, 32'd100, -32'sd100);
    setOp(2, 32'd5, 32'd6);
    setOp(3, -32'sd2, 32'd9);
    applyStimulus(4'b0100, 4'b0000, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b1010, 4'b1011, 1'b0);
      chk("t3 stall ready", 32'(req_ready), 32'h0);
      chk("t3 stall data", resp_data, 32'd30);
      tick();
    end
    applyStimulus(4'b1010, 4'b0100, 1'b0);
    chk("t3 release ready", 32'(req_ready), 32'h8);
    tick();
    chk("t3 req3 data", resp_data, 32'hFFFFFFEE);
    applyStimulus(4'b0010, 4'b1111, 1'b0);
    chk("t3 req1 ready", 32'(req_ready), 32'h2);
    tick();
    chk("t3 req1 id", 32'(resp_id), 32'd1);

    // Overflow wraps silently.
    doReset();
    setOp(0, 32'h7FFFFFFF, 32'd2);
    applyStimulus(4'b0001, 4'b1111, 1'b0);
    tick();
    chk("t4 ovf1", resp_data, 32'hFFFFFFFE);
    setOp(0, 32'h80000000, 32'hFFFFFFFF);
    applyStimulus(4'b0001, 4'b1111, 1'b0);
    tick();
    chk("t4 ovf2", resp_data, 32'h80000000);
    chk("t4 count", op_count, 32'd2);

    // Reset while holding an undrained result.
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    tick();
    chk("t5 resp_valid", 32'(resp_valid), 32'd0);
    chk("t5 op_count", op_count, 32'd0);
    setOp(3, 32'd3, 32'd3);
    applyStimulus(4'b1000, 4'b0000, 1'b0);
    chk("t5 req3 ready", 32'(req_ready), 32'h8);
    tick();
    chk("t5 req3 data", resp_data, 32'd9);

    // Requester 1 withdraws; grant skips to 2 and ID 1 never responds.
    doReset();
    setOp(0, 32'd2, 32'd2);
    setOp(1, 32'd3, 32'd3);
    setOp(2, 32'd4, 32'd4);
    applyStimulus(4'b0111, 4'b1111, 1'b0);
    tick();
    applyStimulus(4'b0100, 4'b1111, 1'b0);
    chk("t6 ready", 32'(req_ready), 32'h4);
    tick();
    chk("t6 id", 32'(resp_id), 32'd2);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b0000, 4'b1111, 1'b0);
      chk("t6 no id1", 32'(resp_valid[1]), 32'd0);
      tick();
    end

    // Randomized traffic with occasional withdrawal and reset.
    doReset();
    v = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (v[i] && $urandom_range(9) == 0) begin
          v[i] = 1'b0;
        end else if (!v[i] && $urandom_range(1) == 1) begin
          v[i] = 1'b1;
          case ($urandom_range(3))
            0: setOp(i, 32'h80000000, 32'($urandom));
            1: setOp(i, 32'h7FFFFFFF, 32'hFFFFFFFF);
            default: setOp(i, 32'($urandom), 32'($urandom));
          endcase
        end
      end
      rr = 4'($urandom_range(15));
      r  = ($urandom_range(99) == 0);
      applyStimulus(v, rr, r);
      tick();
      if (last_acc >= 0) v[last_acc] = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
